// File: rtl/blink_sched.sv
// Programmable LED blink sequencer: plays a latched bit pattern one bit per step,
// with a programmable step period and pass count, entirely in the clk domain.
module blink_sched #(
  parameter int CNT_W = 24,
  parameter int PAT_W = 16,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [7:0]       cfg_reps,
  input  logic             abort,
  output logic             led,
  output logic             step_tick,
  output logic             busy,
  output logic             done
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   per_q, per_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [7:0]         reps_q, reps_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   step_q, step_d;
  logic [7:0]         rep_q, rep_d;
  // Upcoming pattern bits of the current pass; bit 0 is the next step's LED value.
  logic [PAT_W-2:0]   sh_q, sh_d;
  logic               led_q, led_d;
  logic               step_end;

  assign step_end  = (state_q == RUN) && (cnt_q == per_q);
  assign step_tick = step_end && !abort;
  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign led       = led_q;

  // NOTE: every variable gets its default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    pat_d   = pat_q;
    len_d   = len_q;
    reps_d  = reps_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    rep_d   = rep_q;
    sh_d    = sh_q;
    led_d   = led_q;

    unique case (state_q)
      IDLE: begin
        led_d = 1'b0;
        if (cfg_valid) begin
          state_d = RUN;
          per_d   = cfg_period;
          pat_d   = cfg_pattern;
          len_d   = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
          reps_d  = cfg_reps;
          cnt_d   = '0;
          step_d  = '0;
          rep_d   = '0;
          sh_d    = cfg_pattern[PAT_W-1:1];
          led_d   = cfg_pattern[0];
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          led_d   = 1'b0;
          cnt_d   = '0;
          step_d  = '0;
          rep_d   = '0;
        end else if (step_end) begin
          cnt_d = '0;
          if (step_q < len_q) begin
            step_d = step_q + LEN_W'(1);
            led_d  = sh_q[0];
            sh_d   = sh_q >> 1;
          end else if (reps_q == 8'd0 || rep_q < reps_q - 8'd1) begin
            // Endless playback keeps rep_q pinned at all-ones instead of wrapping.
            rep_d  = (rep_q == 8'hFF) ? rep_q : rep_q + 8'd1;
            step_d = '0;
            led_d  = pat_q[0];
            sh_d   = pat_q[PAT_W-1:1];
          end else begin
            state_d = DONE;
            led_d   = 1'b0;
            step_d  = '0;
            rep_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        led_d   = 1'b0;
        cnt_d   = '0;
        step_d  = '0;
        rep_d   = '0;
      end
      default: begin
        state_d = IDLE;
        led_d   = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      per_q   <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      reps_q  <= '0;
      cnt_q   <= '0;
      step_q  <= '0;
      rep_q   <= '0;
      sh_q    <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      reps_q  <= reps_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      rep_q   <= rep_d;
      sh_q    <= sh_d;
      led_q   <= led_d;
    end
  end

endmodule

// File: tb/tb_blink_sched.sv
// Directed self-checking bench for blink_sched; a second instance with PAT_W=8
// shares the stimulus and covers cfg_len clamping.
module tb_blink_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic [23:0] cfg_period;
  logic [15:0] cfg_pattern;
  logic [3:0]  cfg_len;
  logic [7:0]  cfg_reps;
  logic        abort;

  logic cfg_ready, led, step_tick, busy, done;
  logic cfg_ready8, led8, step_tick8, busy8, done8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  blink_sched dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_reps(cfg_reps), .abort(abort), .led(led), .step_tick(step_tick),
    .busy(busy), .done(done)
  );

  blink_sched #(.CNT_W(24), .PAT_W(8), .LEN_W(4)) dut8 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready8),
    .cfg_period(cfg_period), .cfg_pattern(cfg_pattern[7:0]), .cfg_len(cfg_len),
    .cfg_reps(cfg_reps), .abort(abort), .led(led8), .step_tick(step_tick8),
    .busy(busy8), .done(done8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle and settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [23:0] p, input logic [15:0] pat,
                         input logic [3:0] l, input logic [7:0] r);
    cfg_period  = p;
    cfg_pattern = pat;
    cfg_len     = l;
    cfg_reps    = r;
  endtask

  // period=3, pattern=0x5, len=3, reps=1 accepted in cycle 0; optionally hammer cfg_valid
  // with different config for the whole run.
  task automatic run_basic(input bit spam);
    logic exp_led;
    set_cfg(24'd3, 16'h0005, 4'd3, 8'd1);
    cfg_valid = 1'b1;
    chk("basic_ready_c0", cfg_ready, 1);
    for (int c = 1; c <= 18; c++) begin
      tick();
      cfg_valid = spam && (c <= 17);
      if (spam) set_cfg(24'd0, 16'hFFFF, 4'd15, 8'd0);
      exp_led = (c <= 16) ? ((c - 1) / 4 % 2 == 0) : 1'b0;
      chk($sformatf("basic_led_c%0d", c), led, exp_led);
      chk($sformatf("basic_tick_c%0d", c), step_tick, (c <= 16) && (c % 4 == 0));
      chk($sformatf("basic_busy_c%0d", c), busy, c <= 16);
      chk($sformatf("basic_done_c%0d", c), done, c == 17);
      chk($sformatf("basic_ready_c%0d", c), cfg_ready, c >= 18);
    end
    tick();
    chk("basic_stays_idle", busy, 0);
  endtask

  initial begin
    int ticks, dones;
    rst = 1'b1; cfg_valid = 1'b0; abort = 1'b0;
    set_cfg('0, '0, '0, '0);
    tick(); tick();
    rst = 1'b0;
    chk("rst_led", led, 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_tick", step_tick, 0);
    chk("rst_done", done, 0);

    // Reset held two cycles in the middle of a run.
    set_cfg(24'd3, 16'hFFFF, 4'd3, 8'd0);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    repeat (4) tick();
    chk("midrst_busy_before", busy, 1);
    chk("midrst_led_before", led, 1);
    rst = 1'b1;
    tick();
    chk("midrst_done_r1", done, 0);
    tick();
    rst = 1'b0;
    chk("midrst_done_r2", done, 0);
    tick();
    chk("midrst_led", led, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", cfg_ready, 1);
    chk("midrst_done", done, 0);

    // Basic playback, then the same with cfg_valid spammed during the run.
    run_basic(1'b0);
    run_basic(1'b1);

    // period=0: one cycle per step, three passes of a two-step pattern.
    set_cfg(24'd0, 16'h0002, 4'd1, 8'd3);
    cfg_valid = 1'b1;
    ticks = 0; dones = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      cfg_valid = 1'b0;
      if (step_tick) ticks++;
      if (done) dones++;
      chk($sformatf("p0_led_c%0d", c), led, (c <= 6) && (c % 2 == 0));
      chk($sformatf("p0_done_c%0d", c), done, c == 7);
    end
    chk("p0_tick_count", ticks, 6);
    chk("p0_done_count", dones, 1);

    // Endless playback, then abort.
    set_cfg(24'd1, 16'h0001, 4'd0, 8'd0);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    dones = 0; ticks = 0;
    for (int c = 0; c < 1000; c++) begin
      if (done) dones++;
      if (step_tick) ticks++;
      tick();
    end
    chk("endless_done_count", dones, 0);
    chk("endless_tick_count", ticks, 500);
    chk("endless_busy", busy, 1);
    chk("endless_led", led, 1);
    abort = 1'b1;
    chk("abort_no_tick", step_tick, 0);
    tick();
    abort = 1'b0;
    chk("abort_led", led, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", cfg_ready, 1);
    chk("abort_done", done, 0);
    tick();
    chk("abort_done_after", done, 0);

    // abort with cfg_valid in IDLE: config accepted.
    set_cfg(24'd0, 16'h0001, 4'd0, 8'd1);
    cfg_valid = 1'b1;
    abort = 1'b1;
    tick();
    cfg_valid = 1'b0;
    abort = 1'b0;
    chk("idle_abort_busy", busy, 1);
    chk("idle_abort_led", led, 1);
    tick();
    chk("idle_abort_done", done, 1);
    tick();

    // abort during DONE: done still pulses, back to IDLE.
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("done_abort_busy", busy, 1);
    tick();
    abort = 1'b1;
    chk("done_abort_done", done, 1);
    tick();
    abort = 1'b0;
    chk("done_abort_ready", cfg_ready, 1);
    chk("done_abort_idle_done", done, 0);

    // Clamp: cfg_len=15 on an 8-bit pattern plays 8 steps per pass.
    set_cfg(24'd0, 16'h00A5, 4'd15, 8'd2);
    cfg_valid = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      logic [7:0] pat;
      pat = 8'hA5;
      tick();
      cfg_valid = 1'b0;
      chk($sformatf("clamp_led_c%0d", c), led8, (c <= 16) ? pat[(c - 1) % 8] : 1'b0);
      chk($sformatf("clamp_done_c%0d", c), done8, c == 17);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
